// File: rtl/rising_edge_dff_async_reset_high.sv
// rising_edge_dff_async_reset_high
// Basic storage element: a WIDTH-bit D register that captures on the rising
// edge of clk and is forced to RESET_VALUE asynchronously while async_reset
// is high. Q comes straight from the flops with no combinational path.
// Reset release is expected to be synchronized to clk upstream.

`timescale 1ns/1ps

module rising_edge_dff_async_reset_high #(
   parameter int unsigned           WIDTH       = 1,
   parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             async_reset,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);

   // Storage flops: reset has priority over any coincident clock edge.
   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         Q <= RESET_VALUE;
      end else begin
         Q <= D;
      end
   end

endmodule

// File: tb/tb_rising_edge_dff_async_reset_high.sv
// tb_rising_edge_dff_async_reset_high
// Directed bench for the async-reset D register: a 1-bit default instance
// and an 8-bit instance with a non-zero reset value. Expected values are
// pushed into a scoreboard queue when stimulus is applied and popped when
// the DUT output is sampled.

`timescale 1ns/1ps

module tb_rising_edge_dff_async_reset_high;

   logic       clk;
   logic       rst1;
   logic [0:0] d1;
   logic [0:0] q1;
   logic       rst8;
   logic [7:0] d8;
   logic [7:0] q8;

   logic [7:0] expQueue[$];
   int         checks;
   int         failures;

   rising_edge_dff_async_reset_high dutBit (
      .clk         (clk),
      .async_reset (rst1),
      .D           (d1),
      .Q           (q1)
   );

   rising_edge_dff_async_reset_high #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5)
   ) dutByte (
      .clk         (clk),
      .async_reset (rst8),
      .D           (d8),
      .Q           (q8)
   );

   // 80 ns clock: rising edges at 40, 120, 200, ...
   initial begin
      clk = 1'b0;
      forever #40 clk = ~clk;
   end

   // Pop the oldest expected value and compare it with the sampled output.
   task automatic checkOutput(input string tag, input logic [7:0] observed);
      logic [7:0] expected;
      checks++;
      if (expQueue.size() == 0) begin
         failures++;
         $display("[TB] FAIL %s scoreboard empty, observed=%h", tag, observed);
      end else begin
         expected = expQueue.pop_front();
         assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
         end
      end
   endtask

   // One clock cycle on the 1-bit instance: the register should capture the
   // pre-edge D (or the reset value if reset is high), while newD is driven
   // nonblocking at the edge itself.
   task automatic applyStimulus(input string tag, input logic newD);
      expQueue.push_back(rst1 ? 8'h00 : {7'b0, d1});
      @(posedge clk);
      d1 <= newD;
      #1;
      checkOutput(tag, {7'b0, q1});
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      // Reset at time 0, released mid-cycle at 13 ns.
      rst1 = 1'b1;
      d1   = 1'b0;
      rst8 = 1'b1;
      d8   = 8'h00;
      #1;
      expQueue.push_back(8'h00);
      checkOutput("reset_t0", {7'b0, q1});
      expQueue.push_back(8'hA5);
      checkOutput("byte_reset_t0", q8);
      #12;
      expQueue.push_back(8'h00);
      checkOutput("reset_t13", {7'b0, q1});
      rst1 = 1'b0;

      // Single-cycle pulse and return, idle edge, then new capture.
      applyStimulus("edge40_launch", 1'b1);
      applyStimulus("edge120_capture", 1'b0);
      applyStimulus("edge200_return", 1'b0);
      applyStimulus("edge280_hold", 1'b1);
      applyStimulus("edge360_capture", 1'b1);

      // Asynchronous clear mid-cycle at 400 ns.
      #39;
      rst1 = 1'b1;
      #1;
      expQueue.push_back(8'h00);
      checkOutput("async_clear_401", {7'b0, q1});
      applyStimulus("edge440_in_reset", 1'b1);
      #20;
      rst1 = 1'b0;
      #1;
      expQueue.push_back(8'h00);
      checkOutput("after_release", {7'b0, q1});

      // First edge with reset low reloads D, and it keeps holding 1.
      for (int i = 0; i < 6; i++) begin
         applyStimulus($sformatf("post_reset_edge%0d", i), 1'b1);
      end

      // 8-bit instance: reset value, capture, falling edge ignored.
      rst8 = 1'b0;
      @(negedge clk);
      d8 = 8'h3C;
      expQueue.push_back(8'h3C);
      @(posedge clk);
      #1;
      checkOutput("byte_capture_3c", q8);
      @(negedge clk);
      d8 = 8'h5A;
      #1;
      expQueue.push_back(8'h3C);
      checkOutput("byte_negedge_hold", q8);
      expQueue.push_back(8'h5A);
      @(posedge clk);
      #1;
      checkOutput("byte_capture_5a", q8);
      #10;
      rst8 = 1'b1;
      #1;
      expQueue.push_back(8'hA5);
      checkOutput("byte_async_clear", q8);
      expQueue.push_back(8'hA5);
      @(posedge clk);
      #1;
      checkOutput("byte_edge_in_reset", q8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
